// File: rtl/dco_ctrl_pkg.sv
// Shared definitions for the DCO sweep controller family.
package dco_ctrl_pkg;

    // DCO ROM pipeline latency plus two cycles of margin before a step is trusted
    localparam int DCO_ROM_LATENCY       = 4;
    localparam int SETTLE_CYCLES_DEFAULT = DCO_ROM_LATENCY + 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_STEP   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/dco_sweep_controller_if.sv
// Host/config side and DCO/sampler side of the sweep controller.
interface dco_sweep_if #(
    parameter int PHASE_BITS    = 32,
    parameter int DWELL_BITS    = 16,
    parameter int STEP_IDX_BITS = 12
);
    logic                     CE;
    logic                     START;
    logic                     ABORT;
    logic [PHASE_BITS-1:0]    START_INC;
    logic [PHASE_BITS-1:0]    STOP_INC;
    logic [PHASE_BITS-1:0]    STEP_INC;
    logic [DWELL_BITS-1:0]    DWELL_CYCLES;
    logic [PHASE_BITS-1:0]    PHASE_INCREMENT_OUT;
    logic                     PHASE_INCREMENT_OUT_WE;
    logic                     SAMPLE_STROBE;
    logic [STEP_IDX_BITS-1:0] STEP_INDEX;
    logic                     BUSY;
    logic                     DONE;

    modport master (
        output CE, START, ABORT, START_INC, STOP_INC, STEP_INC, DWELL_CYCLES,
        input  PHASE_INCREMENT_OUT, PHASE_INCREMENT_OUT_WE, SAMPLE_STROBE,
               STEP_INDEX, BUSY, DONE
    );

    modport slave (
        input  CE, START, ABORT, START_INC, STOP_INC, STEP_INC, DWELL_CYCLES,
        output PHASE_INCREMENT_OUT, PHASE_INCREMENT_OUT_WE, SAMPLE_STROBE,
               STEP_INDEX, BUSY, DONE
    );
endinterface

// File: rtl/dco_sweep_step_calc.sv
// Next linear-sweep increment and end-of-sweep detection (zero step, wrap, past stop).
module dco_sweep_step_calc #(
    parameter int PHASE_BITS = 32
) (
    input  logic [PHASE_BITS-1:0] cur,
    input  logic [PHASE_BITS-1:0] step,
    input  logic [PHASE_BITS-1:0] stop,
    output logic [PHASE_BITS-1:0] nxt,
    output logic                  last
);
    logic [PHASE_BITS:0] sum;

    assign sum  = {1'b0, cur} + {1'b0, step};
    assign nxt  = sum[PHASE_BITS-1:0];
    assign last = (step == '0) | sum[PHASE_BITS] | (sum > {1'b0, stop});
endmodule

// File: rtl/dco_sweep_controller.sv
// Linear frequency sweep sequencer for the sin/cos DCO: load, settle, dwell, strobe, step.
module dco_sweep_controller
    import dco_ctrl_pkg::*;
#(
    parameter int PHASE_BITS    = 32,
    parameter int DWELL_BITS    = 16,
    parameter int STEP_IDX_BITS = 12,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    dco_sweep_if.slave bus
);
    localparam logic [DWELL_BITS-1:0] SETTLE_LAST = DWELL_BITS'(SETTLE_CYCLES - 1);

    state_t                   state;
    logic [PHASE_BITS-1:0]    stop_q, step_q, out_q;
    logic [DWELL_BITS-1:0]    dwell_q, cnt;
    logic [DWELL_BITS-1:0]    dwell_last;
    logic [STEP_IDX_BITS-1:0] idx_q;
    logic                     busy_q, strobe_q, done_q;
    logic [PHASE_BITS-1:0]    nxt;
    logic                     last;

    // A programmed dwell of 0 behaves as a single cycle
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

    dco_sweep_step_calc #(.PHASE_BITS(PHASE_BITS)) u_calc (
        .cur  (out_q),
        .step (step_q),
        .stop (stop_q),
        .nxt  (nxt),
        .last (last)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            out_q    <= '0;
            cnt      <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.CE) begin
            if (bus.ABORT && state != ST_IDLE) begin
                state    <= ST_IDLE;
                busy_q   <= 1'b0;
                strobe_q <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.START && !bus.ABORT) begin
                            stop_q  <= bus.STOP_INC;
                            step_q  <= bus.STEP_INC;
                            dwell_q <= bus.DWELL_CYCLES;
                            out_q   <= bus.START_INC;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            state   <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt      <= '0;
                            strobe_q <= (dwell_last == '0);
                            state    <= ST_DWELL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    // strobe_q is pre-computed so it is high during the last dwell cycle
                    ST_DWELL: begin
                        if (cnt == dwell_last) begin
                            strobe_q <= 1'b0;
                            state    <= ST_STEP;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            strobe_q <= ((cnt + 1'b1) == dwell_last);
                        end
                    end
                    ST_STEP: begin
                        if (last) begin
                            done_q <= 1'b1;
                            state  <= ST_FINISH;
                        end else begin
                            out_q <= nxt;
                            idx_q <= idx_q + 1'b1;
                            cnt   <= '0;
                            state <= ST_SETTLE;
                        end
                    end
                    ST_FINISH: begin
                        done_q <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Pulses and WE are registered flags qualified by the current CE (and ABORT),
    // so each fires exactly once per enabled cycle and never while frozen.
    assign bus.PHASE_INCREMENT_OUT    = out_q;
    assign bus.STEP_INDEX             = idx_q;
    assign bus.BUSY                   = busy_q;
    assign bus.PHASE_INCREMENT_OUT_WE = bus.CE & busy_q;
    assign bus.SAMPLE_STROBE          = bus.CE & ~bus.ABORT & strobe_q;
    assign bus.DONE                   = bus.CE & ~bus.ABORT & done_q;
endmodule

// File: tb/tb_dco_sweep_controller.sv
// Table-driven sweep checks with a strobe scoreboard, plus abort and async-reset sequences.
module tb_dco_sweep_controller;
    localparam int PB = 32;
    localparam int DB = 16;
    localparam int IB = 12;
    localparam int SC = 6;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    dco_sweep_if #(.PHASE_BITS(PB), .DWELL_BITS(DB), .STEP_IDX_BITS(IB)) bus ();

    dco_sweep_controller #(
        .PHASE_BITS(PB), .DWELL_BITS(DB), .STEP_IDX_BITS(IB), .SETTLE_CYCLES(SC)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic [PB-1:0] start;
        logic [PB-1:0] stop;
        logic [PB-1:0] step;
        logic [DB-1:0] dwell;
        bit            rand_ce;
        int            n_exp;
        logic [PB-1:0] last_exp;
    } vec_t;

    typedef struct {
        logic [PB-1:0] out;
        logic [IB-1:0] idx;
        int            when;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_sweep(input vec_t v, input int id);
        logic [PB:0]   nxt;
        logic [PB-1:0] cur;
        exp_t          e;
        int n, d, bcnt, ndone, nstrobe, done_at;
        bit finished;
        d   = (v.dwell == 0) ? 1 : int'(v.dwell);
        cur = v.start;
        n   = 0;
        forever begin
            sb.push_back('{cur, IB'(n), 1 + SC + d + n * (SC + 1 + d)});
            n++;
            nxt = {1'b0, cur} + {1'b0, v.step};
            if (v.step == 0 || nxt[PB] || nxt > {1'b0, v.stop}) break;
            cur = nxt[PB-1:0];
        end
        done_at = 2 + n * (SC + 1 + d);

        @(negedge CLK);
        bus.START_INC    = v.start;
        bus.STOP_INC     = v.stop;
        bus.STEP_INC     = v.step;
        bus.DWELL_CYCLES = v.dwell;
        bus.CE           = 1'b1;
        bus.START        = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        bcnt = 0; ndone = 0; nstrobe = 0; finished = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.CE = v.rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.BUSY && bus.CE) bcnt++;
            if (bcnt > 0 && !bus.BUSY) begin
                finished = 1;
                break;
            end
            if (!bus.CE) chk($sformatf("v%0d_we_ce0", id), 64'(bus.PHASE_INCREMENT_OUT_WE), 64'd0);
            if (bus.SAMPLE_STROBE) begin
                nstrobe++;
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d_extra_strobe", id), 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_strobe_out", id), 64'(bus.PHASE_INCREMENT_OUT), 64'(e.out));
                    chk($sformatf("v%0d_strobe_idx", id), 64'(bus.STEP_INDEX), 64'(e.idx));
                    chk($sformatf("v%0d_strobe_when", id), 64'(bcnt), 64'(e.when));
                end
            end
            if (bus.DONE) begin
                ndone++;
                chk($sformatf("v%0d_done_when", id), 64'(bcnt), 64'(done_at));
            end
            @(negedge CLK);
        end
        chk($sformatf("v%0d_finished", id), 64'(finished), 64'd1);
        chk($sformatf("v%0d_strobes", id), 64'(nstrobe), 64'(v.n_exp));
        chk($sformatf("v%0d_pending", id), 64'(sb.size()), 64'd0);
        chk($sformatf("v%0d_dones", id), 64'(ndone), 64'd1);
        chk($sformatf("v%0d_busy_cycles", id), 64'(bcnt), 64'(done_at));
        chk($sformatf("v%0d_out_held", id), 64'(bus.PHASE_INCREMENT_OUT), 64'(v.last_exp));
        bus.CE = 1'b1;
        #1;
        chk($sformatf("v%0d_we_idle", id), 64'(bus.PHASE_INCREMENT_OUT_WE), 64'd0);
        sb.delete();
    endtask

    task automatic start_basic(input logic [DB-1:0] dwell);
        @(negedge CLK);
        bus.START_INC    = 32'd1000;
        bus.STOP_INC     = 32'd1300;
        bus.STEP_INC     = 32'd100;
        bus.DWELL_CYCLES = dwell;
        bus.CE           = 1'b1;
        bus.START        = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    initial begin
        int ns, nd;
        bit got;
        vecs[0] = '{32'd1000, 32'd1300, 32'd100, 16'd3, 1'b0, 4, 32'd1300};
        vecs[1] = '{32'd500,  32'd100,  32'd100, 16'd3, 1'b0, 1, 32'd500};
        vecs[2] = '{32'd500,  32'd2000, 32'd0,   16'd2, 1'b0, 1, 32'd500};
        vecs[3] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd1, 1'b0, 2, 32'hFFFF_FF80};
        vecs[4] = '{32'd1000, 32'd1300, 32'd100, 16'd0, 1'b0, 4, 32'd1300};
        vecs[5] = '{32'd1000, 32'd1300, 32'd100, 16'd3, 1'b1, 4, 32'd1300};

        RESET = 1'b0;
        bus.CE = 1'b1; bus.START = 1'b0; bus.ABORT = 1'b0;
        bus.START_INC = '0; bus.STOP_INC = '0; bus.STEP_INC = '0; bus.DWELL_CYCLES = '0;
        #12;
        chk("rst_out",    64'(bus.PHASE_INCREMENT_OUT), 64'd0);
        chk("rst_we",     64'(bus.PHASE_INCREMENT_OUT_WE), 64'd0);
        chk("rst_strobe", 64'(bus.SAMPLE_STROBE), 64'd0);
        chk("rst_idx",    64'(bus.STEP_INDEX), 64'd0);
        chk("rst_busy",   64'(bus.BUSY), 64'd0);
        chk("rst_done",   64'(bus.DONE), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Async reset in the middle of SETTLE, checked before the next clock edge
        start_basic(16'd3);
        repeat (3) @(negedge CLK);
        #3 RESET = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.BUSY), 64'd0);
        chk("arst_out",  64'(bus.PHASE_INCREMENT_OUT), 64'd0);
        chk("arst_we",   64'(bus.PHASE_INCREMENT_OUT_WE), 64'd0);
        chk("arst_idx",  64'(bus.STEP_INDEX), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        foreach (vecs[i]) run_sweep(vecs[i], i);

        // Abort in the strobe cycle of step 2, with a START-while-busy attempt beforehand
        start_basic(16'd1);
        got = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            #1;
            if (bus.STEP_INDEX == IB'(2)) begin
                got = 1;
                break;
            end
        end
        chk("abort_reach_step2", 64'(got), 64'd1);
        bus.START_INC = 32'd7;
        bus.START     = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        #1;
        chk("busy_start_out", 64'(bus.PHASE_INCREMENT_OUT), 64'd1200);
        chk("busy_start_idx", 64'(bus.STEP_INDEX), 64'd2);
        repeat (5) @(negedge CLK);
        bus.ABORT = 1'b1;
        #1;
        chk("abort_strobe_suppr", 64'(bus.SAMPLE_STROBE), 64'd0);
        chk("abort_busy_same",    64'(bus.BUSY), 64'd1);
        @(negedge CLK);
        bus.ABORT = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.BUSY), 64'd0);
        chk("abort_we",   64'(bus.PHASE_INCREMENT_OUT_WE), 64'd0);
        chk("abort_done", 64'(bus.DONE), 64'd0);
        chk("abort_out",  64'(bus.PHASE_INCREMENT_OUT), 64'd1200);
        ns = 0; nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            #1;
            if (bus.SAMPLE_STROBE) ns++;
            if (bus.DONE) nd++;
        end
        chk("abort_no_strobe", 64'(ns), 64'd0);
        chk("abort_no_done",   64'(nd), 64'd0);

        // START together with ABORT in IDLE is ignored
        @(negedge CLK);
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        #1;
        chk("start_abort_idle", 64'(bus.BUSY), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
